// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle for one elastic pipeline stage: the upstream feed plus the downstream head.
interface pipe_stage_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int PC_W   = 32
);

  // Valid/ready contract, evaluated on the rising clock edge:
  //   an entry moves when valid & ready are both high. Once valid is raised and ready is low,
  //   the source must hold valid and payload unchanged until the transfer happens. Ready may
  //   change freely, and valid must never wait on ready.
  logic              In_Valid;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;
  logic [PC_W-1:0]   In_PC;

  logic              Out_Valid;
  logic              Out_Ready;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [PC_W-1:0]   Out_PC;

  modport master (
    output In_Valid, In_Ctrl, In_Data, In_PC, Out_Ready,
    input  In_Ready, Out_Valid, Out_Ctrl, Out_Data, Out_PC
  );

  modport slave (
    input  In_Valid, In_Ctrl, In_Data, In_PC, Out_Ready,
    output In_Ready, Out_Valid, Out_Ctrl, Out_Data, Out_PC
  );

endinterface

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register. It has an optional two-entry skid, flush to bubble,
// and saturating stall/flush counters.
module pipe_stage_buffer #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 16,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  pipe_stage_buffer_if.slave bus,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // The state encoding is the occupancy, so the state is visible on the Occupancy port.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [PC_W-1:0]   head_pc_q, head_pc_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic pop;

  assign out_valid = (state_q != ST_EMPTY);
  // With the skid enabled, ready comes from a flop and never sees Out_Ready.
  assign in_ready  = SKID_EN ? in_ready_q : (~out_valid | bus.Out_Ready);
  assign accept    = bus.In_Valid & in_ready;
  assign pop       = out_valid & bus.Out_Ready;

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;

    if (Flush) begin
      // The payload registers are not touched, so a same-cycle input is dropped and the head data stays put.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            head_ctrl_d = bus.In_Ctrl;
            head_data_d = bus.In_Data;
            head_pc_d   = bus.In_PC;
          end
        end
        ST_ONE: begin
          if (accept && (pop || !SKID_EN)) begin
            head_ctrl_d = bus.In_Ctrl;
            head_data_d = bus.In_Data;
            head_pc_d   = bus.In_PC;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_ctrl_d = bus.In_Ctrl;
            skid_data_d = bus.In_Data;
            skid_pc_d   = bus.In_PC;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
            head_pc_d   = skid_pc_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !bus.Out_Ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (Flush && out_valid && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_EMPTY;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Masking the control word makes an empty stage look like a bubble downstream.
  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = out_valid;
  assign bus.Out_Ctrl  = out_valid ? head_ctrl_q : '0;
  assign bus.Out_Data  = head_data_q;
  assign bus.Out_PC    = head_pc_q;

  assign Occupancy  = state_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
